// File: rtl/tiny_proc_pkg.sv
// Shared definitions for the tiny processor load/run sequencer.
// Optional feature macro: LOAD_PARITY_EN (adds a trailing even-parity bit per load frame).
package tiny_proc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Sequencer states; the encoding is fixed so a bound checker can decode it.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IRECV = 3'd1,
    ST_DRECV = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Frame width helper: data bits, then address bits, then optional parity bit.
  function automatic int frame_w(input int data_w, input int addr_w, input bit parity);
    return data_w + addr_w + (parity ? 1 : 0);
  endfunction

  localparam int FRAME_W_PLAIN  = frame_w(DATA_W_DEF, ADDR_W_DEF, 1'b0);
  localparam int FRAME_W_PARITY = frame_w(DATA_W_DEF, ADDR_W_DEF, 1'b1);

endpackage

// File: rtl/frame_deserializer.sv
// Serial load frame deserializer: MSB-first shift register, bit counter and
// optional even-parity check (macro LOAD_PARITY_EN). Emits one-cycle
// frame_valid/frame_bad pulses combinationally in the cycle of the last bit.
module frame_deserializer
  import tiny_proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,     // first bit of a new burst: count restarts at 0
  input  logic              shift_in,     // sample bit_in this cycle
  input  logic              bit_in,
  output logic              frame_valid_out,
  output logic              frame_bad_out,
  output logic [DATA_W-1:0] frame_data_out,
  output logic [ADDR_W-1:0] frame_addr_out,
  output logic              bit_cnt_nz_out
);

`ifdef LOAD_PARITY_EN
  localparam int FRAME_W = frame_w(DATA_W, ADDR_W, 1'b1);
`else
  localparam int FRAME_W = frame_w(DATA_W, ADDR_W, 1'b0);
`endif
  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic [FRAME_W-1:0] frame_full;
  logic               last_bit;
  logic               frame_ok;

  // Shift/count next-state and frame decode for the bit being sampled now.
  always_comb begin
    cnt_base   = start_in ? '0 : cnt_q;
    frame_full = {shift_q, bit_in};
    last_bit   = shift_in && (cnt_base == CNT_LAST);
    shift_d    = shift_q;
    cnt_d      = cnt_base;
    if (shift_in) begin
      shift_d = frame_full[FRAME_W-2:0];
      cnt_d   = last_bit ? '0 : cnt_base + CNT_W'(1);
    end
`ifdef LOAD_PARITY_EN
    frame_ok = ~(^frame_full);
`else
    frame_ok = 1'b1;
`endif
  end

  assign frame_valid_out = last_bit && frame_ok;
  assign frame_bad_out   = last_bit && !frame_ok;
  assign frame_data_out  = frame_full[FRAME_W-1 -: DATA_W];
  assign frame_addr_out  = frame_full[FRAME_W-1-DATA_W -: ADDR_W];
  assign bit_cnt_nz_out  = (cnt_q != '0);

  // Shift register and bit counter; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_load_ctrl.sv
// Load/run sequencer: deserializes icache/dcache load frames into one-cycle
// write strobes and gates program execution with a cycle watchdog.
// Optional feature macro: LOAD_PARITY_EN (handled in frame_deserializer).
// Handshake: a write is a single-cycle wen pulse; mem_addr_out/mem_data_out
// are valid in that cycle and hold until the next committed frame.
module mem_load_ctrl
  import tiny_proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WDOG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mosi_in,
  input  logic              csi_n_in,
  input  logic              csd_n_in,
  input  logic              run_req_in,
  input  logic              proc_halt_in,
  output logic              imem_wen_out,
  output logic              dmem_wen_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              pc_rst_out,
  output logic              exec_en_out,
  output logic              ready_out,
  output logic              done_out,
  output logic              timeout_out,
  output logic              frame_err_out,
  output logic [ADDR_W:0]   word_cnt_out
);

  localparam logic [ADDR_W:0]   WORD_MAX  = (ADDR_W+1)'(1 << ADDR_W);
  // Last watchdog value still inside RUN; the next step reaches all-ones.
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  state_e              state_q, state_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                timeout_q, timeout_d;
  logic                frame_err_q, frame_err_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                imem_wen_q, imem_wen_d;
  logic                dmem_wen_q, dmem_wen_d;

  logic                des_start, des_shift;
  logic                frame_valid, frame_bad, bit_cnt_nz;
  logic [DATA_W-1:0]   frame_data;
  logic [ADDR_W-1:0]   frame_addr;

  frame_deserializer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_deser (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_in        (des_start),
    .shift_in        (des_shift),
    .bit_in          (mosi_in),
    .frame_valid_out (frame_valid),
    .frame_bad_out   (frame_bad),
    .frame_data_out  (frame_data),
    .frame_addr_out  (frame_addr),
    .bit_cnt_nz_out  (bit_cnt_nz)
  );

  // Next-state, sticky flags, watchdog and commit logic.
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    frame_err_d = frame_err_q;
    word_cnt_d  = word_cnt_q;
    des_start   = 1'b0;
    des_shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run_req_in) begin
          state_d   = ST_RUN;
          wdog_d    = '0;
          timeout_d = 1'b0;
        end else if (!csi_n_in || !csd_n_in) begin
          // The entry cycle already samples the first frame bit.
          state_d     = !csi_n_in ? ST_IRECV : ST_DRECV;
          des_start   = 1'b1;
          des_shift   = 1'b1;
          word_cnt_d  = '0;
          frame_err_d = 1'b0;
        end
      end
      ST_IRECV, ST_DRECV: begin
        if ((state_q == ST_IRECV) ? !csi_n_in : !csd_n_in) begin
          des_shift = 1'b1;
        end else begin
          state_d = ST_IDLE;
          if (bit_cnt_nz) frame_err_d = 1'b1;
        end
      end
      ST_RUN: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (!run_req_in) begin
          state_d = ST_IDLE;
        end else if (proc_halt_in) begin
          state_d = ST_DONE;
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!run_req_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_valid && (word_cnt_q != WORD_MAX)) word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
    if (frame_bad) frame_err_d = 1'b1;
    imem_wen_d = frame_valid && (state_q == ST_IRECV);
    dmem_wen_d = frame_valid && (state_q == ST_DRECV);
    addr_d     = frame_valid ? frame_addr : addr_q;
    data_d     = frame_valid ? frame_data : data_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Registered datapath, flags and write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
      frame_err_q <= 1'b0;
      word_cnt_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      imem_wen_q  <= 1'b0;
      dmem_wen_q  <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      frame_err_q <= frame_err_d;
      word_cnt_q  <= word_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      imem_wen_q  <= imem_wen_d;
      dmem_wen_q  <= dmem_wen_d;
    end
  end

  assign imem_wen_out  = imem_wen_q;
  assign dmem_wen_out  = dmem_wen_q;
  assign mem_addr_out  = addr_q;
  assign mem_data_out  = data_q;
  assign timeout_out   = timeout_q;
  assign frame_err_out = frame_err_q;
  assign word_cnt_out  = word_cnt_q;
  assign ready_out     = (state_q == ST_IDLE);
  assign done_out      = (state_q == ST_DONE);
  assign exec_en_out   = (state_q == ST_RUN);
  assign pc_rst_out    = !((state_q == ST_RUN) || (state_q == ST_DONE));

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed bench for mem_load_ctrl with a write scoreboard.
// Honours LOAD_PARITY_EN the same way as the design.
module tb_mem_load_ctrl;

`ifdef LOAD_PARITY_EN
  localparam int FW = 13;
`else
  localparam int FW = 12;
`endif
  localparam int EW = 13;  // {is_dmem, addr[3:0], data[7:0]}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mosi_in = 1'b0;
  logic       csi_n_in = 1'b1;
  logic       csd_n_in = 1'b1;
  logic       run_req_in = 1'b0;
  logic       proc_halt_in = 1'b0;
  logic       imem_wen_out, dmem_wen_out;
  logic [3:0] mem_addr_out;
  logic [7:0] mem_data_out;
  logic       pc_rst_out, exec_en_out, ready_out, done_out;
  logic       timeout_out, frame_err_out;
  logic [4:0] word_cnt_out;

  mem_load_ctrl #(.DATA_W(8), .ADDR_W(4), .WDOG_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mosi_in       (mosi_in),
    .csi_n_in      (csi_n_in),
    .csd_n_in      (csd_n_in),
    .run_req_in    (run_req_in),
    .proc_halt_in  (proc_halt_in),
    .imem_wen_out  (imem_wen_out),
    .dmem_wen_out  (dmem_wen_out),
    .mem_addr_out  (mem_addr_out),
    .mem_data_out  (mem_data_out),
    .pc_rst_out    (pc_rst_out),
    .exec_en_out   (exec_en_out),
    .ready_out     (ready_out),
    .done_out      (done_out),
    .timeout_out   (timeout_out),
    .frame_err_out (frame_err_out),
    .word_cnt_out  (word_cnt_out)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int iwen_cnt = 0;
  int dwen_cnt = 0;
  int first_dwen = -1;
  int last_dwen = -1;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] make_frame(input logic [7:0] d, input logic [3:0] a);
`ifdef LOAD_PARITY_EN
    return {d, a, ^{d, a}};
`else
    return {d, a};
`endif
  endfunction

  // Drive bits f[hi]..f[lo] with the chosen select low, one per cycle.
  task automatic send_bits(input bit use_d, input logic [FW-1:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      if (use_d) csd_n_in = 1'b0; else csi_n_in = 1'b0;
      mosi_in = f[i];
      @(negedge clk);
    end
  endtask

  task automatic load_word(input bit use_d, input logic [7:0] d, input logic [3:0] a);
    exp_q.push_back({use_d, a, d});
    send_bits(use_d, make_frame(d, a), FW-1, 0);
  endtask

  task automatic release_sel();
    csi_n_in = 1'b1;
    csd_n_in = 1'b1;
    mosi_in  = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && (imem_wen_out || dmem_wen_out)) begin
      if (imem_wen_out) iwen_cnt++;
      if (dmem_wen_out) begin
        dwen_cnt++;
        if (first_dwen < 0) first_dwen = cyc;
        last_dwen = cyc;
      end
      chk("wen_one_hot", 32'(imem_wen_out && dmem_wen_out), 32'd0);
      chk("wen_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wen_payload", 32'({dmem_wen_out, mem_addr_out, mem_data_out}), 32'(mon_e));
      end
    end
  end

  int n_exec;
  logic [FW-1:0] f;

  initial begin
    // Reset values.
    #1;
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_pc_rst", 32'(pc_rst_out), 32'd1);
    chk("rst_outputs", 32'({imem_wen_out, dmem_wen_out, mem_addr_out, mem_data_out, exec_en_out,
                            done_out, timeout_out, frame_err_out, word_cnt_out}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single imem frame, select released in the wen cycle.
    load_word(1'b0, 8'hA5, 4'h3);
    chk("imem_wen_now", 32'(imem_wen_out), 32'd1);
    release_sel();
    chk("imem_wen_single", 32'(imem_wen_out), 32'd0);
    @(negedge clk); #1;
    chk("imem_cnt", 32'(iwen_cnt), 32'd1);
    chk("imem_word_cnt", 32'(word_cnt_out), 32'd1);
    chk("imem_hold", 32'({mem_addr_out, mem_data_out}), 32'h3A5);
    chk("imem_err", 32'(frame_err_out), 32'd0);
    chk("imem_idle", 32'(ready_out), 32'd1);

    // 17 back-to-back dmem frames: no gaps, word count saturates at 16.
    first_dwen = -1;
    for (int i = 0; i < 17; i++) load_word(1'b1, 8'(8'h10 + i), 4'(i));
    release_sel();
    @(negedge clk); #1;
    chk("burst_dwen_cnt", 32'(dwen_cnt), 32'd17);
    chk("burst_spacing", 32'(last_dwen - first_dwen), 32'(16 * FW));
    chk("burst_word_sat", 32'(word_cnt_out), 32'd16);
    chk("burst_last_hold", 32'({mem_addr_out, mem_data_out}), 32'h020);

    // Partial frame: 7 bits then release.
    f = make_frame(8'h3C, 4'h6);
    send_bits(1'b1, f, FW-1, FW-7);
    release_sel();
    #1;
    chk("partial_err", 32'(frame_err_out), 32'd1);
    chk("partial_idle", 32'(ready_out), 32'd1);
    chk("partial_no_wen", 32'(dwen_cnt), 32'd17);
    chk("partial_word_cnt", 32'(word_cnt_out), 32'd0);

    // Next load entry clears the error; the frame then commits.
    f = make_frame(8'h5A, 4'h9);
    exp_q.push_back({1'b1, 4'h9, 8'h5A});
    send_bits(1'b1, f, FW-1, FW-1);
    chk("entry_clears_err", 32'(frame_err_out), 32'd0);
    send_bits(1'b1, f, FW-2, 0);
    release_sel();
    @(negedge clk); #1;
    chk("after_err_commit", 32'(dwen_cnt), 32'd18);
    chk("after_err_word_cnt", 32'(word_cnt_out), 32'd1);

    // Asynchronous reset mid-frame: partial frame dropped, no write.
    f = make_frame(8'hFF, 4'hF);
    send_bits(1'b0, f, FW-1, FW-5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_out), 32'd1);
    chk("midrst_word_cnt", 32'(word_cnt_out), 32'd0);
    @(negedge clk);
    csi_n_in = 1'b1;
    mosi_in  = 1'b0;
    rst_n    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_wen", 32'(iwen_cnt), 32'd1);

    // Run with halt at exec cycle 20.
    run_req_in = 1'b1;
    @(negedge clk);
    chk("run_exec_en", 32'({exec_en_out, pc_rst_out, ready_out}), 32'b100);
    repeat (19) @(negedge clk);
    chk("run_exec_c20", 32'(exec_en_out), 32'd1);
    proc_halt_in = 1'b1;
    @(negedge clk);
    chk("halt_done", 32'({done_out, exec_en_out, pc_rst_out, timeout_out}), 32'b1000);
    run_req_in   = 1'b0;
    proc_halt_in = 1'b0;
    @(negedge clk);
    chk("halt_back_idle", 32'({ready_out, done_out, pc_rst_out}), 32'b101);

    // Run without halt: watchdog ends it after 255 exec cycles.
    run_req_in = 1'b1;
    n_exec = 0;
    for (int i = 0; i < 400 && !done_out; i++) begin
      @(negedge clk);
      if (exec_en_out) n_exec++;
    end
    chk("wdog_done", 32'(done_out), 32'd1);
    chk("wdog_exec_cycles", 32'(n_exec), 32'd255);
    chk("wdog_timeout", 32'(timeout_out), 32'd1);
    run_req_in = 1'b0;
    @(negedge clk);
    chk("wdog_sticky", 32'({ready_out, timeout_out}), 32'b11);

    // Halt on the last watchdog cycle: halt wins, timeout cleared on entry.
    run_req_in = 1'b1;
    @(negedge clk);
    chk("rerun_timeout_clr", 32'(timeout_out), 32'd0);
    repeat (254) @(negedge clk);
    chk("edge_exec", 32'(exec_en_out), 32'd1);
    proc_halt_in = 1'b1;
    @(negedge clk);
    chk("edge_halt_wins", 32'({done_out, timeout_out}), 32'b10);
    run_req_in   = 1'b0;
    proc_halt_in = 1'b0;
    @(negedge clk);

`ifdef LOAD_PARITY_EN
    // Bad parity frame followed back-to-back by a good one.
    f = make_frame(8'h77, 4'h5) ^ FW'(1);
    send_bits(1'b1, f, FW-1, 0);
    #1;
    chk("par_err", 32'(frame_err_out), 32'd1);
    chk("par_stay", 32'({ready_out, word_cnt_out}), 32'd0);
    load_word(1'b1, 8'h66, 4'hC);
    release_sel();
    @(negedge clk); #1;
    chk("par_good_commit", 32'(dwen_cnt), 32'd19);
    chk("par_word_cnt", 32'(word_cnt_out), 32'd1);
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("total_imem", 32'(iwen_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
